// File: rtl/joy_io_sync.sv
// joy_io_sync: synchronised and debounced joypad inputs, latched pad outputs and the 68K read mux.
// Defining JOY_IO_PRESS_LATCH_EN adds per-bit sticky press latches cleared by reads.
module joy_io_sync #(
  parameter int NUM_PLAYERS     = 2,
  parameter int IN_WIDTH        = 10,
  parameter int OUT_WIDTH       = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                             CLK_24M,
  input  logic                             RESET,
  input  logic [NUM_PLAYERS-1:0]           nCTRL_ZONE,
  input  logic                             nSTATUSBZONE,
  input  logic                             nSTATUSCZONE,
  input  logic                             nBITWD0,
  input  logic                             M68K_ADDR_A4,
  input  logic [15:0]                      DATA_IN,
  output logic [15:0]                      DATA_OUT,
  output logic                             DATA_OE,
  input  logic [NUM_PLAYERS*IN_WIDTH-1:0]  PAD_IN,
  input  logic                             nWP,
  input  logic                             nCD2,
  input  logic                             nCD1,
  input  logic                             SYSTEM_MODE,
  output logic [NUM_PLAYERS*OUT_WIDTH-1:0] PAD_OUT
);

  localparam int NB = NUM_PLAYERS * IN_WIDTH;
  localparam int PW = NUM_PLAYERS * OUT_WIDTH;

  logic [NB-1:0] sync1_q;
  logic [NB-1:0] sync2_q;
  logic [NB-1:0] deb_cur;
`ifdef JOY_IO_PRESS_LATCH_EN
  logic [NB-1:0] deb_nxt;
`endif

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= PAD_IN;
      sync2_q <= sync1_q;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign deb_cur = sync2_q;
`ifdef JOY_IO_PRESS_LATCH_EN
      assign deb_nxt = sync1_q;
`endif
    end else begin : g_debounce
      localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [NB-1:0] deb_q;
      logic [NB-1:0] deb_d;
      logic [CW-1:0] cnt_q [NB];
      logic [CW-1:0] cnt_d [NB];

      // A bit is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NB; i++) begin
          cnt_d[i] = '0;
          if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
              deb_d[i] = sync2_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
      end

      always_ff @(posedge CLK_24M) begin
        if (RESET) begin
          deb_q <= '1;
          for (int i = 0; i < NB; i++) begin
            cnt_q[i] <= '0;
          end
        end else begin
          deb_q <= deb_d;
          for (int i = 0; i < NB; i++) begin
            cnt_q[i] <= cnt_d[i];
          end
        end
      end

      assign deb_cur = deb_q;
`ifdef JOY_IO_PRESS_LATCH_EN
      assign deb_nxt = deb_d;
`endif
    end
  endgenerate

  logic          wd_s1_q;
  logic          wd_s2_q;
  logic          wd_prev_q;
  logic          wr_fire;
  logic [PW-1:0] pad_out_q;
  logic [PW-1:0] pad_out_d;

  // Write strobe is asynchronous: resynchronise, then act once per falling edge.
  assign wr_fire   = wd_prev_q & ~wd_s2_q & ~M68K_ADDR_A4;
  assign pad_out_d = wr_fire ? DATA_IN[PW-1:0] : pad_out_q;

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      wd_s1_q   <= 1'b1;
      wd_s2_q   <= 1'b1;
      wd_prev_q <= 1'b1;
      pad_out_q <= '0;
    end else begin
      wd_s1_q   <= nBITWD0;
      wd_s2_q   <= wd_s1_q;
      wd_prev_q <= wd_s2_q;
      pad_out_q <= pad_out_d;
    end
  end

  assign PAD_OUT = pad_out_q;

  generate
    if (PW < 16) begin : g_unused
      logic unused_data;
      assign unused_data = ^DATA_IN[15:PW];
    end
  endgenerate

  logic [NB-1:0] pval_flat;

`ifdef JOY_IO_PRESS_LATCH_EN
  logic [NB-1:0]          latch_q;
  logic [NB-1:0]          latch_d;
  logic [NB-1:0]          latch_clr;
  logic [NUM_PLAYERS-1:0] zone_prev_q;
  logic                   stb_prev_q;
  logic                   stc_prev_q;

  // Clears follow the rising edge of the zone that exposes the bits; a new press wins.
  always_comb begin
    latch_clr = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int b = 0; b < IN_WIDTH; b++) begin
        if (b < 8 && !zone_prev_q[p] && nCTRL_ZONE[p]) latch_clr[p*IN_WIDTH+b] = 1'b1;
        if (b >= 8 && p < 2 && !stb_prev_q && nSTATUSBZONE) latch_clr[p*IN_WIDTH+b] = 1'b1;
        if (b >= 8 && p >= 2 && !stc_prev_q && nSTATUSCZONE) latch_clr[p*IN_WIDTH+b] = 1'b1;
      end
    end
    latch_d = (latch_q & ~latch_clr) | (deb_cur & ~deb_nxt);
  end

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      latch_q     <= '0;
      zone_prev_q <= '1;
      stb_prev_q  <= 1'b1;
      stc_prev_q  <= 1'b1;
    end else begin
      latch_q     <= latch_d;
      zone_prev_q <= nCTRL_ZONE;
      stb_prev_q  <= nSTATUSBZONE;
      stc_prev_q  <= nSTATUSCZONE;
    end
  end

  assign pval_flat = deb_cur & ~latch_q;
`else
  assign pval_flat = deb_cur;
`endif

  logic [1:0] hi [4];
  logic [7:0] rd_byte;

  // Bits 9:8 of absent players or of 9-bit pads read as released.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      hi[p] = 2'b11;
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int b = 8; b < IN_WIDTH; b++) begin
        hi[p][b-8] = pval_flat[p*IN_WIDTH+b];
      end
    end
  end

  // Later assignments override earlier ones, giving lowest-index CTRL zone top priority.
  always_comb begin
    rd_byte = 8'h00;
    if (!nSTATUSCZONE) rd_byte = {4'hF, hi[3], hi[2]};
    if (!nSTATUSBZONE) rd_byte = {SYSTEM_MODE, nWP, nCD2, nCD1, hi[1], hi[0]};
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (!nCTRL_ZONE[p]) rd_byte = pval_flat[p*IN_WIDTH +: 8];
    end
  end

  assign DATA_OE  = ~(&nCTRL_ZONE) | ~nSTATUSBZONE | ~nSTATUSCZONE;
  assign DATA_OUT = {rd_byte, 8'h00};

endmodule
